// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: FSM encoding, default base address
// and the address range helper used by the per-port range checkers.
package data_memory_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  // Word-aligned and inside [base, base + 4*depth); the unsigned compare rejects addresses below base.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] base,
                                         input logic [ADDR_W-1:0] depth);
    logic [ADDR_W-1:0] offset;
    offset = addr - base;
    return (addr >= base) && ((offset >> 2) < depth) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/data_memory_addr_check.sv
// Combinational range/alignment check of one requester's byte address against the data memory window.
module data_memory_addr_check
  import data_memory_arbiter_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int unsigned       MEMORY_DEPTH = 512
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  assign in_range = addr_in_range(addr, BASE_ADDR, ADDR_W'(MEMORY_DEPTH));

endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter with burst limit sharing the single-port data memory between
// the core (port 0) and a peripheral/debug master (port 1); read data is returned registered.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int unsigned           MEMORY_DEPTH = 512,
  parameter int unsigned           MAX_BURST    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [DATA_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  err0,
  output logic                  err1,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  arb_state_e            state_q, state_d;
  logic                  last_owner_q, last_owner_d;
  logic [BURST_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic                  err0_q, err0_d, err1_q, err1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  in_range0, in_range1;

  data_memory_addr_check #(
    .BASE_ADDR   (BASE_ADDR),
    .MEMORY_DEPTH(MEMORY_DEPTH)
  ) u_addr_check0 (
    .addr    (addr0),
    .in_range(in_range0)
  );

  data_memory_addr_check #(
    .BASE_ADDR   (BASE_ADDR),
    .MEMORY_DEPTH(MEMORY_DEPTH)
  ) u_addr_check1 (
    .addr    (addr1),
    .in_range(in_range1)
  );

  // Out-of-range grants still drive the address but never enable the memory.
  always_comb begin
    gnt0      = (state_q == ST_OWN0) && req0;
    gnt1      = (state_q == ST_OWN1) && req1;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    if (gnt0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
      mem_write = we0 && in_range0;
      mem_read  = !we0 && in_range0;
    end else if (gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_write = we1 && in_range1;
      mem_read  = !we1 && in_range1;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req0 && req1) state_d = last_owner_q ? ST_OWN0 : ST_OWN1;
        else if (req0)    state_d = ST_OWN0;
        else if (req1)    state_d = ST_OWN1;
      end
      ST_OWN0: begin
        if (!req0) begin
          state_d = req1 ? ST_OWN1 : ST_IDLE;
        end else begin
          last_owner_d = 1'b0;
          if (burst_cnt_q == BURST_LAST && req1) state_d = ST_OWN1;
          else if (burst_cnt_q != BURST_LAST)    burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end
      end
      ST_OWN1: begin
        if (!req1) begin
          state_d = req0 ? ST_OWN0 : ST_IDLE;
        end else begin
          last_owner_d = 1'b1;
          if (burst_cnt_q == BURST_LAST && req0) state_d = ST_OWN0;
          else if (burst_cnt_q != BURST_LAST)    burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The count saturates rather than wraps so a long solo burst still yields promptly.
    if (state_d != state_q) burst_cnt_d = '0;
  end

  always_comb begin
    rvalid0_d = gnt0 && !we0;
    rvalid1_d = gnt1 && !we1;
    err0_d    = gnt0 && !in_range0;
    err1_d    = gnt1 && !in_range1;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    if (gnt0 && !we0) rdata0_d = in_range0 ? mem_rdata : '0;
    if (gnt1 && !we1) rdata1_d = in_range1 ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a behavioural 512-word data memory behind it.
module tb_data_memory_arbiter;

  localparam logic [31:0] BASE   = 32'h1001_0000;
  localparam logic [31:0] A_0    = 32'h1001_0000;
  localparam logic [31:0] A_4    = 32'h1001_0004;
  localparam logic [31:0] A_LAST = 32'h1001_07FC;
  localparam logic [31:0] A_LOW  = 32'h1000_FFFC;
  localparam logic [31:0] A_HIGH = 32'h1001_0800;
  localparam logic [31:0] A_MIS  = 32'h1001_0002;

  logic        clk, reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  int vectorCount = 0;
  int errorCount  = 0;

  data_memory_arbiter #(
    .DATA_WIDTH  (32),
    .BASE_ADDR   (BASE),
    .MEMORY_DEPTH(512),
    .MAX_BURST   (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .we0      (we0),
    .we1      (we1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .err0     (err0),
    .err1     (err1),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_write(mem_write),
    .mem_read (mem_read),
    .mem_rdata(mem_rdata)
  );

  // Data memory: combinational read, synchronous write, indexed by word offset from BASE.
  logic [31:0] memArray [0:511];
  logic [31:0] memOffset;
  assign memOffset = mem_addr - BASE;
  assign mem_rdata = (memOffset < 32'd2048) ? memArray[memOffset[10:2]] : 32'h0;
  always @(posedge clk) if (mem_write) memArray[memOffset[10:2]] <= mem_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Advances one clock, drives the new inputs just after the edge and settles before checks.
  task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    @(posedge clk);
    #1;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
  endtask

  task automatic checkPorts(input string tag, input logic g0, input logic g1, input logic mw, input logic mr);
    checkOutput({tag, "_gnt0"}, 32'(gnt0), 32'(g0));
    checkOutput({tag, "_gnt1"}, 32'(gnt1), 32'(g1));
    checkOutput({tag, "_mem_write"}, 32'(mem_write), 32'(mw));
    checkOutput({tag, "_mem_read"}, 32'(mem_read), 32'(mr));
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    repeat (2) @(posedge clk);
    #1;
    checkPorts("rst", 0, 0, 0, 0);
    checkOutput("rst_rvalid0", 32'(rvalid0), 0);
    checkOutput("rst_err1", 32'(err1), 0);
    checkOutput("rst_rdata0", rdata0, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    reset = 1'b1;

    $display("[TB] write then read back on port 0");
    applyStimulus(1, 1, A_4, 32'hDEAD_BEEF, 0, 0, 0, 0);
    checkPorts("t1_idle", 0, 0, 0, 0);
    applyStimulus(1, 1, A_4, 32'hDEAD_BEEF, 0, 0, 0, 0);
    checkPorts("t1_wr", 1, 0, 1, 0);
    checkOutput("t1_wr_addr", mem_addr, A_4);
    checkOutput("t1_wr_data", mem_wdata, 32'hDEAD_BEEF);
    applyStimulus(1, 0, A_4, 0, 0, 0, 0, 0);
    checkPorts("t1_rd", 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkPorts("t1_drop", 0, 0, 0, 0);
    checkOutput("t1_mem_addr_idle", mem_addr, 0);
    checkOutput("t1_rvalid0", 32'(rvalid0), 1);
    checkOutput("t1_rdata0", rdata0, 32'hDEAD_BEEF);
    checkOutput("t1_err0", 32'(err0), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_rvalid0_pulse", 32'(rvalid0), 0);
    checkOutput("t1_rdata0_hold", rdata0, 32'hDEAD_BEEF);

    $display("[TB] tie arbitration");
    doReset();
    applyStimulus(1, 0, A_4, 0, 1, 0, A_4, 0);
    checkPorts("t2_idle", 0, 0, 0, 0);
    applyStimulus(1, 0, A_4, 0, 1, 0, A_4, 0);
    checkPorts("t2_first", 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, A_4, 0);
    checkPorts("t2_handover", 0, 0, 0, 0);
    checkOutput("t2_rvalid0", 32'(rvalid0), 1);
    applyStimulus(0, 0, 0, 0, 1, 0, A_4, 0);
    checkPorts("t2_second", 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_rvalid1", 32'(rvalid1), 1);
    checkOutput("t2_rdata1", rdata1, 32'hDEAD_BEEF);
    applyStimulus(1, 0, A_4, 0, 1, 0, A_4, 0);
    checkPorts("t2_tie2_idle", 0, 0, 0, 0);
    applyStimulus(1, 0, A_4, 0, 1, 0, A_4, 0);
    checkPorts("t2_tie2", 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkPorts("t2_back_idle", 0, 0, 0, 0);

    $display("[TB] burst limit");
    applyStimulus(1, 0, A_4, 0, 0, 0, 0, 0);
    checkPorts("t3_idle", 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, A_4, 0, 1, 0, A_4, 0);
      checkPorts($sformatf("t3_p0_%0d", i), 1, 0, 0, 1);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, A_4, 0, 1, 0, A_4, 0);
      checkPorts($sformatf("t3_p1_%0d", i), 0, 1, 0, 1);
    end
    applyStimulus(1, 0, A_4, 0, 1, 0, A_4, 0);
    checkPorts("t3_back0", 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkPorts("t3_idle_end", 0, 0, 0, 0);

    $display("[TB] out-of-range and misaligned accesses");
    applyStimulus(1, 0, A_LOW, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, A_LOW, 0, 0, 0, 0, 0);
    checkPorts("t4_low", 1, 0, 0, 0);
    applyStimulus(1, 1, A_HIGH, 32'h5555_AAAA, 0, 0, 0, 0);
    checkPorts("t4_high", 1, 0, 0, 0);
    checkOutput("t4_low_err", 32'(err0), 1);
    checkOutput("t4_low_rvalid", 32'(rvalid0), 1);
    checkOutput("t4_low_rdata", rdata0, 0);
    applyStimulus(1, 0, A_MIS, 0, 0, 0, 0, 0);
    checkPorts("t4_mis", 1, 0, 0, 0);
    checkOutput("t4_high_err", 32'(err0), 1);
    checkOutput("t4_high_rvalid", 32'(rvalid0), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_mis_err", 32'(err0), 1);
    checkOutput("t4_mis_rvalid", 32'(rvalid0), 1);
    checkOutput("t4_mis_rdata", rdata0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_err_pulse", 32'(err0), 0);

    $display("[TB] port 1 writes, port 0 reads back");
    applyStimulus(0, 0, 0, 0, 1, 1, A_0, 32'h1234_5678);
    applyStimulus(0, 0, 0, 0, 1, 1, A_0, 32'h1234_5678);
    checkPorts("t6_wr0", 0, 1, 1, 0);
    checkOutput("t6_wr0_data", mem_wdata, 32'h1234_5678);
    applyStimulus(0, 0, 0, 0, 1, 1, A_LAST, 32'hCAFE_F00D);
    checkPorts("t6_wr_last", 0, 1, 1, 0);
    checkOutput("t6_wr_last_addr", mem_addr, A_LAST);
    applyStimulus(1, 0, A_0, 0, 0, 0, 0, 0);
    checkPorts("t6_switch", 0, 0, 0, 0);
    checkOutput("t6_err1", 32'(err1), 0);
    applyStimulus(1, 0, A_0, 0, 0, 0, 0, 0);
    checkPorts("t6_rd0", 1, 0, 0, 1);
    applyStimulus(1, 0, A_LAST, 0, 0, 0, 0, 0);
    checkPorts("t6_rd_last", 1, 0, 0, 1);
    checkOutput("t6_rdata0_a", rdata0, 32'h1234_5678);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_rdata0_b", rdata0, 32'hCAFE_F00D);
    checkOutput("t6_err0", 32'(err0), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] reset during read return");
    applyStimulus(1, 0, A_4, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, A_4, 0, 0, 0, 0, 0);
    checkPorts("t5_rd", 1, 0, 0, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkPorts("t5_rst", 0, 0, 0, 0);
    checkOutput("t5_rvalid0", 32'(rvalid0), 0);
    checkOutput("t5_rdata0", rdata0, 0);
    checkOutput("t5_mem_addr", mem_addr, 0);
    @(posedge clk);
    #1;
    checkOutput("t5_rvalid0_held", 32'(rvalid0), 0);
    reset = 1'b1;
    req1 = 1'b1; we1 = 1'b0; addr1 = A_4;
    applyStimulus(1, 0, A_4, 0, 1, 0, A_4, 0);
    checkPorts("t5_tie", 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
    $finish;
  end

endmodule
